alu_issue_ctrl: RTL and testbench
=================================

Name: alu_issue_ctrl

Overview:
Command front-end that sits directly upstream of the 16-bit registered ALU.
- Accepts tagged ALU commands (opcode, two operands, tag) over a valid/ready interface and buffers them in a small FIFO.
- Issues one command at a time to the ALU's OPCODE/OP1/OP2 inputs and captures RESULT/CARRY/ZERO at the correct cycle.
- Returns each result with its tag over a valid/ready response interface, with full backpressure.

Parameters:
- OPCODE_WIDTH, 2, MSB index of opcode bus (opcode is OPCODE_WIDTH+1 = 3 bits).
- DATA_WIDTH, 15, MSB index of operand/result bus (16 bits).
- TAG_WIDTH, 3, MSB index of tag bus (4 bits).
- FIFO_DEPTH, 4, command FIFO entries; power of two, at least 2.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rstn  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  FIFO can accept a command; equals !full.
- cmd_opcode  in  OPCODE_WIDTH+1  ALU opcode 0..7.
- cmd_op1  in  DATA_WIDTH+1  operand 1.
- cmd_op2  in  DATA_WIDTH+1  operand 2.
- cmd_tag  in  TAG_WIDTH+1  opaque ID, returned unchanged.
- alu_opcode  out  OPCODE_WIDTH+1  drives ALU OPCODE.
- alu_op1  out  DATA_WIDTH+1  drives ALU OP1.
- alu_op2  out  DATA_WIDTH+1  drives ALU OP2.
- alu_result  in  DATA_WIDTH+1  from ALU RESULT.
- alu_carry  in  1  from ALU CARRY.
- alu_zero  in  1  from ALU ZERO.
- rsp_valid  out  1  response held.
- rsp_ready  in  1  consumer accepts response.
- rsp_result  out  DATA_WIDTH+1  captured RESULT.
- rsp_carry  out  1  captured CARRY.
- rsp_zero  out  1  captured ZERO.
- rsp_tag  out  TAG_WIDTH+1  tag of the issued command.
- busy  out  1  high when FSM is not IDLE or FIFO is not empty.

Behaviour:
Reset:
- rstn low clears the FIFO (pointers and count 0), puts the FSM in IDLE, and drives all alu_*, rsp_* and busy outputs to 0.
- cmd_ready is 1 in reset.
- The ALU shares rstn. Reset mid-operation drops all queued and in-flight commands; no response is produced for them.

FIFO:
- Push on cmd_valid && cmd_ready. Pop is controlled by the FSM.
- Simultaneous push and pop when full is not allowed: cmd_ready = !full, so no push occurs while full, even if a pop happens that cycle.
- Simultaneous push and pop when not full: count unchanged, both pointers advance.
- Pointers wrap modulo FIFO_DEPTH. The count uses clog2(FIFO_DEPTH)+1 bits.
- Push into an empty FIFO is visible to the FSM on the next cycle; there is no fall-through.

FSM states: IDLE, ISSUE, CAPT, RESP.
- IDLE: if FIFO is non-empty, pop the head, register it onto alu_opcode/op1/op2 and an internal tag register, then go to ISSUE.
- ISSUE: alu_* held stable; the ALU samples them at this state's closing edge. Go to CAPT unconditionally.
- CAPT: ALU outputs now reflect the issued command. Register alu_result/carry/zero into rsp_result/carry/zero, copy the tag to rsp_tag, set rsp_valid, and go to RESP.
- RESP: rsp_valid stays high and rsp_* are held stable until rsp_ready.
  - On rsp_ready with FIFO non-empty: clear rsp_valid, pop and issue the next command, go to ISSUE (back-to-back).
  - On rsp_ready with FIFO empty: clear rsp_valid, go to IDLE.
- alu_* keep their last issued value outside ISSUE; they do not return to 0.

Timing:
- Latency from command accept edge N (FIFO previously empty, FSM IDLE): pop at N+1, rsp_valid high after edge N+3.
- Sustained throughput with rsp_ready=1 is one command per 3 cycles.
- Responses return in command order. Carry, zero and result are passed through bit-exact; no arithmetic is done in this block.
- Opcodes are forwarded unchecked; all values 0..7 are legal.

Decomposition:
- Shared package alu_pkg:
  - opcode constants OP_ADD=0, OP_SUB=1, OP_INC=2, OP_DEC=3, OP_AND=4, OP_OR=5, OP_NAND=6, OP_XOR=7;
  - FSM state enum;
  - packed command struct {opcode, op1, op2, tag}.
- One sub-module, alu_cmd_fifo: parameterised synchronous FIFO with push, pop, full, empty and count, holding the command struct.
- The FSM and response registers live in alu_issue_ctrl.
- The verification top instantiates alu_issue_ctrl connected to the existing ALU.

Test Plan:
- Reset behaviour: assert rstn low mid-RESP with 2 commands queued → rsp_valid=0, busy=0 and cmd_ready=1 immediately; after release, no response appears for the dropped commands.
- Carry/zero and latency: single ADD 0xFFFF+0x0001 tag=5, rsp_ready=1 → rsp_valid exactly 3 edges after accept; result=0x0000, carry=1, zero=1, tag=5.
- Back-to-back in order: push SUB 0x0005-0x0007 (tag 1), NAND 0x00FF,0x0F0F (tag 2), DEC 0x0001 (tag 3), rsp_ready=1 → responses in order:
  - tag 1: 0xFFFE, carry=1, zero=0;
  - tag 2: 0xFFF0, carry=1 (ALU reports the raw top bit), zero=0;
  - tag 3: 0x0000, zero=1;
  - spacing 3 cycles.
- FIFO full/backpressure: rsp_ready=0, push 6 XOR commands → first issued and held in RESP, FIFO holds 4, cmd_ready=0 on the 6th; release rsp_ready → all 5 accepted commands return in order with stable rsp_* while stalled.
- Wrap-around: stream 20 INC commands (op1 = tag index) with random rsp_ready → every response equals op1+1 with the matching tag; no loss or duplication across pointer wrap.
- Simultaneous push/pop: push a command on the same edge the FSM pops the last entry → count stays 1, and that command is issued next.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU command front-end: default bus widths (as MSB
// indices), opcode encodings, FSM state type and the queued command record.
package alu_pkg;

  localparam int unsigned OPCODE_MSB = 2;   // 3-bit opcode
  localparam int unsigned DATA_MSB   = 15;  // 16-bit operands/result
  localparam int unsigned TAG_MSB    = 3;   // 4-bit tag

  localparam logic [OPCODE_MSB:0] OP_ADD  = 3'd0;
  localparam logic [OPCODE_MSB:0] OP_SUB  = 3'd1;
  localparam logic [OPCODE_MSB:0] OP_INC  = 3'd2;
  localparam logic [OPCODE_MSB:0] OP_DEC  = 3'd3;
  localparam logic [OPCODE_MSB:0] OP_AND  = 3'd4;
  localparam logic [OPCODE_MSB:0] OP_OR   = 3'd5;
  localparam logic [OPCODE_MSB:0] OP_NAND = 3'd6;
  localparam logic [OPCODE_MSB:0] OP_XOR  = 3'd7;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StCapt,
    StResp
  } alu_state_e;

  typedef struct packed {
    logic [OPCODE_MSB:0] opcode;
    logic [DATA_MSB:0]   op1;
    logic [DATA_MSB:0]   op2;
    logic [TAG_MSB:0]    tag;
  } alu_cmd_t;

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// Command and response handshake bundle for alu_issue_ctrl.
//   cmd_*: tagged command in (valid/ready), master drives valid and payload.
//   rsp_*: tagged result out (valid/ready), master drives ready.
// master = command producer / response consumer; slave = alu_issue_ctrl.
interface alu_issue_ctrl_if
  import alu_pkg::*;
#(
  parameter int unsigned OPCODE_WIDTH = OPCODE_MSB,
  parameter int unsigned DATA_WIDTH   = DATA_MSB,
  parameter int unsigned TAG_WIDTH    = TAG_MSB
) ();

  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [OPCODE_WIDTH:0] cmd_opcode;
  logic [DATA_WIDTH:0]   cmd_op1;
  logic [DATA_WIDTH:0]   cmd_op2;
  logic [TAG_WIDTH:0]    cmd_tag;

  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH:0]   rsp_result;
  logic                  rsp_carry;
  logic                  rsp_zero;
  logic [TAG_WIDTH:0]    rsp_tag;

  modport master (
    output cmd_valid, cmd_opcode, cmd_op1, cmd_op2, cmd_tag, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_result, rsp_carry, rsp_zero, rsp_tag
  );

  modport slave (
    input  cmd_valid, cmd_opcode, cmd_op1, cmd_op2, cmd_tag, rsp_ready,
    output cmd_ready, rsp_valid, rsp_result, rsp_carry, rsp_zero, rsp_tag
  );

endinterface

// File: rtl/alu_cmd_fifo.sv
// Synchronous command FIFO, no fall-through (a pushed entry is visible at the
// head from the next cycle).
//   clk, rstn   : clock, async active-low reset (clears pointers and count)
//   push, wdata : write strobe and entry; ignored when full
//   pop, rdata  : read strobe and head entry; pop ignored when empty
//   full, empty : status flags
//   count       : occupancy, clog2(FIFO_DEPTH)+1 bits
module alu_cmd_fifo
  import alu_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter type         entry_t    = alu_cmd_t
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          push,
  input  entry_t                        wdata,
  input  logic                          pop,
  output entry_t                        rdata,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH):0]   count
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam logic [PtrW:0] FullCount = FIFO_DEPTH[PtrW:0];

  entry_t            mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]     count_q, count_d;
  logic              do_push, do_pop;

  assign full    = (count_q == FullCount);
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rdata   = mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    count_d = count_q;
    if (do_push && !do_pop) begin
      count_d = count_q + (PtrW + 1)'(1);
    end else if (!do_push && do_pop) begin
      count_d = count_q - (PtrW + 1)'(1);
    end
  end

  // Power-of-two depth: pointers wrap by natural overflow.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue controller in front of the registered 16-bit ALU. Buffers tagged
// commands, issues one at a time, captures the ALU outputs two edges after
// issue and returns them with the command's tag.
//   clk, rstn          : clock, async active-low reset (shared with the ALU)
//   bus (slave)        : cmd_* in / rsp_* out handshakes
//   alu_opcode/op1/op2 : registered drive into the ALU, held between issues
//   alu_result/carry/zero : ALU outputs, sampled in the capture state
//   busy               : FSM not idle or commands still queued
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int unsigned OPCODE_WIDTH = OPCODE_MSB,
  parameter int unsigned DATA_WIDTH   = DATA_MSB,
  parameter int unsigned TAG_WIDTH    = TAG_MSB,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic                  clk,
  input  logic                  rstn,
  alu_issue_ctrl_if.slave       bus,
  output logic [OPCODE_WIDTH:0] alu_opcode,
  output logic [DATA_WIDTH:0]   alu_op1,
  output logic [DATA_WIDTH:0]   alu_op2,
  input  logic [DATA_WIDTH:0]   alu_result,
  input  logic                  alu_carry,
  input  logic                  alu_zero,
  output logic                  busy
);

  localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;

  typedef struct packed {
    logic [OPCODE_WIDTH:0] opcode;
    logic [DATA_WIDTH:0]   op1;
    logic [DATA_WIDTH:0]   op2;
    logic [TAG_WIDTH:0]    tag;
  } cmd_t;

  cmd_t            fifo_wdata, fifo_head;
  logic            fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [CntW-1:0] fifo_count;

  alu_state_e            state_q, state_d;
  logic [OPCODE_WIDTH:0] opcode_q, opcode_d;
  logic [DATA_WIDTH:0]   op1_q, op1_d, op2_q, op2_d;
  logic [TAG_WIDTH:0]    tag_q, tag_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH:0]   rsp_result_q, rsp_result_d;
  logic                  rsp_carry_q, rsp_carry_d;
  logic                  rsp_zero_q, rsp_zero_d;
  logic [TAG_WIDTH:0]    rsp_tag_q, rsp_tag_d;

  assign fifo_wdata = '{opcode: bus.cmd_opcode, op1: bus.cmd_op1,
                        op2: bus.cmd_op2, tag: bus.cmd_tag};
  assign fifo_push  = bus.cmd_valid && !fifo_full;

  alu_cmd_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .entry_t    (cmd_t)
  ) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (fifo_push),
    .wdata (fifo_wdata),
    .pop   (fifo_pop),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    state_d      = state_q;
    fifo_pop     = 1'b0;
    opcode_d     = opcode_q;
    op1_d        = op1_q;
    op2_d        = op2_q;
    tag_d        = tag_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_result_d = rsp_result_q;
    rsp_carry_d  = rsp_carry_q;
    rsp_zero_d   = rsp_zero_q;
    rsp_tag_d    = rsp_tag_q;

    unique case (state_q)
      StIdle: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          opcode_d = fifo_head.opcode;
          op1_d    = fifo_head.op1;
          op2_d    = fifo_head.op2;
          tag_d    = fifo_head.tag;
          state_d  = StIssue;
        end
      end
      // ALU registers its inputs at the closing edge of this state.
      StIssue: state_d = StCapt;
      StCapt: begin
        rsp_valid_d  = 1'b1;
        rsp_result_d = alu_result;
        rsp_carry_d  = alu_carry;
        rsp_zero_d   = alu_zero;
        rsp_tag_d    = tag_q;
        state_d      = StResp;
      end
      StResp: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          if (!fifo_empty) begin
            // Back-to-back: issue the next command on the accept edge.
            fifo_pop = 1'b1;
            opcode_d = fifo_head.opcode;
            op1_d    = fifo_head.op1;
            op2_d    = fifo_head.op2;
            tag_d    = fifo_head.tag;
            state_d  = StIssue;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= StIdle;
      opcode_q     <= '0;
      op1_q        <= '0;
      op2_q        <= '0;
      tag_q        <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_result_q <= '0;
      rsp_carry_q  <= 1'b0;
      rsp_zero_q   <= 1'b0;
      rsp_tag_q    <= '0;
    end else begin
      state_q      <= state_d;
      opcode_q     <= opcode_d;
      op1_q        <= op1_d;
      op2_q        <= op2_d;
      tag_q        <= tag_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_result_q <= rsp_result_d;
      rsp_carry_q  <= rsp_carry_d;
      rsp_zero_q   <= rsp_zero_d;
      rsp_tag_q    <= rsp_tag_d;
    end
  end

  assign bus.cmd_ready  = !fifo_full;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_result = rsp_result_q;
  assign bus.rsp_carry  = rsp_carry_q;
  assign bus.rsp_zero   = rsp_zero_q;
  assign bus.rsp_tag    = rsp_tag_q;

  assign alu_opcode = opcode_q;
  assign alu_op1    = op1_q;
  assign alu_op2    = op2_q;
  assign busy       = (state_q != StIdle) || (fifo_count != '0);

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl with a behavioural registered ALU attached.
// Stimulus pushes hand-computed expected responses into a queue; a monitor
// pops and compares on every response handshake.
module tb_alu_issue_ctrl;
  import alu_pkg::*;

  typedef struct packed {
    logic [15:0] r;
    logic        c;
    logic        z;
    logic [3:0]  t;
  } exp_t;

  logic        clk = 1'b0;
  logic        rstn;
  logic [2:0]  alu_opcode;
  logic [15:0] alu_op1, alu_op2, alu_result;
  logic        alu_carry, alu_zero, busy;
  logic [16:0] alu_nxt;

  int unsigned cyc = 0;
  int          n_cmp = 0;
  int          n_fail = 0;
  int          hs_cnt = 0;
  exp_t        exp_q[$];
  int unsigned hs_cyc[$];
  bit          rand_done;

  alu_issue_ctrl_if bus ();

  alu_issue_ctrl dut (
    .clk        (clk),
    .rstn       (rstn),
    .bus        (bus),
    .alu_opcode (alu_opcode),
    .alu_op1    (alu_op1),
    .alu_op2    (alu_op2),
    .alu_result (alu_result),
    .alu_carry  (alu_carry),
    .alu_zero   (alu_zero),
    .busy       (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Registered ALU model: carry is bit 16 for arithmetic, raw top bit for logic.
  function automatic logic [16:0] alu_f(input logic [2:0] op, input logic [15:0] a,
                                        input logic [15:0] b);
    logic [16:0] res;
    case (op)
      OP_ADD:  res = {1'b0, a} + {1'b0, b};
      OP_SUB:  res = {1'b0, a} - {1'b0, b};
      OP_INC:  res = {1'b0, a} + 17'd1;
      OP_DEC:  res = {1'b0, a} - 17'd1;
      OP_AND:  res = {a[15] & b[15], a & b};
      OP_OR:   res = {a[15] | b[15], a | b};
      OP_NAND: res = {~(a[15] & b[15]), ~(a & b)};
      default: res = {a[15] ^ b[15], a ^ b};
    endcase
    return res;
  endfunction

  always_comb alu_nxt = alu_f(alu_opcode, alu_op1, alu_op2);

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      alu_result <= '0;
      alu_carry  <= 1'b0;
      alu_zero   <= 1'b0;
    end else begin
      alu_result <= alu_nxt[15:0];
      alu_carry  <= alu_nxt[16];
      alu_zero   <= (alu_nxt[15:0] == 16'h0000);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: timed out, expected event did not occur", name);
  endtask

  task automatic send(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                      input logic [3:0] t, input logic [15:0] er, input logic ec,
                      input logic ez);
    int n = 0;
    @(negedge clk);
    bus.cmd_valid  = 1'b1;
    bus.cmd_opcode = op;
    bus.cmd_op1    = a;
    bus.cmd_op2    = b;
    bus.cmd_tag    = t;
    while (!bus.cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus.cmd_ready) begin
      timeout("send_accept");
      bus.cmd_valid = 1'b0;
    end else begin
      @(posedge clk);
      exp_q.push_back('{r: er, c: ec, z: ez, t: t});
      #1 bus.cmd_valid = 1'b0;
    end
  endtask

  task automatic set_ready(input logic v);
    @(posedge clk);
    #1 bus.rsp_ready = v;
  endtask

  task automatic wait_valid();
    int n = 0;
    @(negedge clk);
    while (!bus.rsp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!bus.rsp_valid) timeout("wait_rsp_valid");
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) timeout("drain");
  endtask

  // Scoreboard monitor: compare on handshake, check payload stability while stalled.
  initial begin
    exp_t cur, prev, e;
    bit   stalled;
    stalled = 1'b0;
    forever begin
      @(negedge clk);
      if (rstn && bus.rsp_valid) begin
        cur = '{r: bus.rsp_result, c: bus.rsp_carry, z: bus.rsp_zero, t: bus.rsp_tag};
        if (stalled) chk("stall_stable", 32'(cur), 32'(prev));
        if (bus.rsp_ready) begin
          hs_cnt++;
          hs_cyc.push_back(cyc);
          stalled = 1'b0;
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected_rsp: got 0x%0h, expected no response", cur);
          end else begin
            e = exp_q.pop_front();
            chk("rsp", 32'(cur), 32'(e));
          end
        end else begin
          stalled = 1'b1;
          prev    = cur;
        end
      end else begin
        stalled = 1'b0;
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned acc, base;
    rstn           = 1'b0;
    bus.cmd_valid  = 1'b0;
    bus.cmd_opcode = '0;
    bus.cmd_op1    = '0;
    bus.cmd_op2    = '0;
    bus.cmd_tag    = '0;
    bus.rsp_ready  = 1'b0;
    rand_done      = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_cmd_ready", bus.cmd_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_alu_opcode", alu_opcode, 0);
    chk("rst_alu_op1", alu_op1, 0);
    chk("rst_rsp_tag", bus.rsp_tag, 0);
    @(posedge clk);
    #1 rstn = 1'b1;

    // Single ADD: wrap to zero with carry, latency 3 edges after accept
    set_ready(1'b1);
    send(OP_ADD, 16'hFFFF, 16'h0001, 4'd5, 16'h0000, 1'b1, 1'b1);
    acc = cyc;
    wait_valid();
    chk("latency", cyc - acc, 3);
    wait_drain(20);

    // Back-to-back in order, 3-cycle spacing
    hs_cyc.delete();
    send(OP_SUB,  16'h0005, 16'h0007, 4'd1, 16'hFFFE, 1'b1, 1'b0);
    send(OP_NAND, 16'h00FF, 16'h0F0F, 4'd2, 16'hFFF0, 1'b1, 1'b0);
    send(OP_DEC,  16'h0001, 16'h0000, 4'd3, 16'h0000, 1'b0, 1'b1);
    wait_drain(40);
    chk("b2b_count", hs_cyc.size(), 3);
    if (hs_cyc.size() == 3) begin
      chk("b2b_spacing_0", hs_cyc[1] - hs_cyc[0], 3);
      chk("b2b_spacing_1", hs_cyc[2] - hs_cyc[1], 3);
    end

    // FIFO full with response stalled
    set_ready(1'b0);
    send(OP_XOR, 16'hFFFF, 16'h0F0F, 4'd0, 16'hF0F0, 1'b1, 1'b0);
    send(OP_XOR, 16'h1234, 16'h1234, 4'd1, 16'h0000, 1'b0, 1'b1);
    send(OP_XOR, 16'h8000, 16'h0001, 4'd2, 16'h8001, 1'b1, 1'b0);
    send(OP_XOR, 16'h00FF, 16'hFF00, 4'd3, 16'hFFFF, 1'b1, 1'b0);
    send(OP_XOR, 16'h5555, 16'h0AAA, 4'd4, 16'h5FFF, 1'b0, 1'b0);
    @(negedge clk);
    bus.cmd_valid  = 1'b1;
    bus.cmd_opcode = OP_XOR;
    bus.cmd_op1    = 16'h1111;
    bus.cmd_op2    = 16'h2222;
    bus.cmd_tag    = 4'd5;
    repeat (3) begin
      @(negedge clk);
      chk("full_cmd_ready", bus.cmd_ready, 0);
    end
    chk("full_count", 32'(dut.u_fifo.count), 4);
    chk("full_rsp_valid", bus.rsp_valid, 1);
    chk("full_busy", busy, 1);
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
    set_ready(1'b1);
    wait_drain(60);

    // Pointer wrap with random backpressure
    base = hs_cnt;
    fork
      begin
        for (int i = 0; i < 20; i++) begin
          send(OP_INC, 16'(i), 16'h0000, 4'(i), 16'(i + 1), 1'b0, 1'b0);
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk);
          #1 bus.rsp_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    set_ready(1'b1);
    wait_drain(200);
    chk("wrap_rsp_count", hs_cnt - base, 20);

    // Push on the same edge the FSM pops the last entry
    set_ready(1'b0);
    send(OP_OR,  16'h0F00, 16'h00F0, 4'd6, 16'h0FF0, 1'b0, 1'b0);
    send(OP_AND, 16'hFF00, 16'h0FF0, 4'd7, 16'h0F00, 1'b0, 1'b0);
    wait_valid();
    @(posedge clk);
    #1;
    chk("simul_pre_count", 32'(dut.u_fifo.count), 1);
    bus.rsp_ready  = 1'b1;
    bus.cmd_valid  = 1'b1;
    bus.cmd_opcode = OP_ADD;
    bus.cmd_op1    = 16'h7FFF;
    bus.cmd_op2    = 16'h0001;
    bus.cmd_tag    = 4'd8;
    @(posedge clk);
    exp_q.push_back('{r: 16'h8000, c: 1'b0, z: 1'b0, t: 4'd8});
    #1 bus.cmd_valid = 1'b0;
    chk("simul_count", 32'(dut.u_fifo.count), 1);
    chk("simul_alu_op1", alu_op1, 16'hFF00);
    wait_drain(40);

    // Reset mid-response with two commands queued
    set_ready(1'b0);
    send(OP_ADD, 16'h0001, 16'h0001, 4'd9,  16'h0002, 1'b0, 1'b0);
    send(OP_ADD, 16'h0002, 16'h0002, 4'd10, 16'h0004, 1'b0, 1'b0);
    send(OP_ADD, 16'h0003, 16'h0003, 4'd11, 16'h0006, 1'b0, 1'b0);
    wait_valid();
    @(posedge clk);
    #1 rstn = 1'b0;
    exp_q.delete();
    #1;
    chk("mid_rst_rsp_valid", bus.rsp_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_cmd_ready", bus.cmd_ready, 1);
    chk("mid_rst_alu_op1", alu_op1, 0);
    base = hs_cnt;
    repeat (2) @(posedge clk);
    #1;
    rstn          = 1'b1;
    bus.rsp_ready = 1'b1;
    repeat (15) @(posedge clk);
    #1;
    chk("post_rst_no_rsp", hs_cnt - base, 0);
    chk("post_rst_busy", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
